sd_answer_checker: RTL
======================

SD_ANSWER_CHECKER -- requirements
Module: sd_answer_checker

Interface
REQ-001 Parameter TIMEOUT, default 1000: maximum cycles allowed from the last puzzle cell to the first answer digit.
REQ-002 Parameter BLANKS, default 15: number of blank cells per puzzle and number of answer digits expected.
REQ-003 clk  input  1  single clock; all logic samples on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  puzzle stream valid; snooped from the solver's input side.
REQ-006 in  input  4  puzzle cell; row-major, 0 = blank, 1-9 = given digit.
REQ-007 out_valid  input  1  answer stream valid; driven by the solver.
REQ-008 out  input  4  answer digit for the next blank, in row-major blank order.
REQ-009 done  output  1  one-cycle pulse when a verdict is ready.
REQ-010 pass  output  1  verdict: 1 = correct solution.
REQ-011 err  output  2  verdict code: 0 ok, 1 timeout, 2 protocol, 3 invalid grid.
REQ-012 latency  output  10  cycles from the last in_valid to the first out_valid, saturating at 1023.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, WAIT, COLLECT, CHECK, REPORT.
REQ-014 IDLE->LOAD on in_valid=1; that cycle SHALL store cell 0 and clear pass, err and latency.
REQ-015 LOAD SHALL store one cell per cycle into the 81x4 grid and record each blank index; the 81st cell SHALL move the FSM to WAIT.
REQ-016 in_valid=0 before the 81st cell, or a blank count other than BLANKS after it, SHALL go to REPORT with err=2.
REQ-017 WAIT SHALL count latency each cycle; out_valid=1 SHALL write the digit into the first blank and go to COLLECT.
REQ-018 COLLECT SHALL write one digit per cycle into the next blank; after BLANKS digits it SHALL go to CHECK.
REQ-019 out_valid=0 inside the BLANKS-cycle burst, out_valid=1 in LOAD, or in_valid=1 in WAIT/COLLECT SHALL go to REPORT with err=2.
REQ-020 An answer digit of 0 or greater than 9 SHALL be stored and later force err=3; the FSM SHALL NOT abort early.
REQ-021 CHECK SHALL evaluate one group per cycle (rows 0-8, columns 0-8, boxes 0-8) for 27 cycles; a group passes iff the OR of the one-hot masks of its 9 cells equals 9'h1FF.
REQ-022 Any failing group SHALL set err=3; CHECK SHALL still run all 27 cycles, so the verdict latency is fixed.
REQ-023 REPORT SHALL last one cycle: done=1, pass=(err==0); then the FSM SHALL return to IDLE.
REQ-024 pass, err and latency SHALL hold after REPORT until the next puzzle starts.
REQ-025 An out_valid burst that follows the final answer digit SHALL be ignored in IDLE.
REQ-026 Given cells SHALL NOT be overwritten by answers; only recorded blank indices SHALL be written.

Reset
REQ-027 rst=1 SHALL force the FSM to IDLE and set done=0, pass=0, err=0 and latency=0 on the next edge, from any state and mid-stream.
REQ-028 The grid and blank index contents SHALL be don't-care after reset; no output SHALL depend on them before the next LOAD.
REQ-029 An in_valid asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-030 Macro SD_CHK_TIMEOUT_EN defined: if WAIT lasts TIMEOUT cycles without out_valid, the FSM SHALL go to REPORT with err=1.
REQ-031 Macro SD_CHK_TIMEOUT_EN undefined: WAIT SHALL be unbounded, and err=1 SHALL never be produced.

Verification
REQ-032 Valid puzzle (15 blanks), correct 15 digits after 5 cycles -> done once 27 cycles after the last digit (plus REPORT), pass=1, err=0, latency=5.
REQ-033 Same puzzle with the 7th answer digit wrong (duplicate in its row) -> pass=0, err=3, same done timing.
REQ-034 in_valid drops at cell 40 -> REPORT next cycle with err=2; out_valid gap at digit 8 -> err=2.
REQ-035 Puzzle with 14 blanks -> err=2 immediately after the 81st cell.
REQ-036 With SD_CHK_TIMEOUT_EN and TIMEOUT=20, no out_valid -> done at WAIT cycle 20 with err=1; without the macro -> no done after 2000 cycles.
REQ-037 rst pulsed mid-COLLECT -> outputs zero next cycle; a new full puzzle then passes normally.

Source files
------------

// File: rtl/sd_answer_checker.sv
// sd_answer_checker: snoops a sudoku solver's puzzle and answer streams,
// rebuilds the solved grid and checks every row, column and 3x3 box.
// Optional feature: define SD_CHK_TIMEOUT_EN to bound the wait for the
// first answer digit to TIMEOUT cycles (err=1 on expiry).
module sd_answer_checker #(
   parameter int TIMEOUT = 1000,
   parameter int BLANKS  = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] in,
   input  logic       out_valid,
   input  logic [3:0] out,
   output logic       done,
   output logic       pass,
   output logic [1:0] err,
   output logic [9:0] latency
);

   localparam int BW = (BLANKS > 1) ? $clog2(BLANKS) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, WAIT, COLLECT, CHECK, REPORT} state_t;

   state_t     state, state_n;
   logic [1:0] err_n;
   logic [6:0] cnt, nblank, nblank_nx;
   logic [BW-1:0] dig;
   logic [4:0] grp;
   logic       in_blank, grp_ok, timeout_hit;
   logic [8:0] mask;
   logic [3:0] grid [0:80];
   logic [6:0] bidx [0:(2**BW)-1];

   // Digits outside 1..9 contribute no bit, so they fail every group they sit in.
   function automatic logic [8:0] onehot(input logic [3:0] v);
      if (v >= 4'd1 && v <= 4'd9) return 9'd1 << (v - 4'd1);
      else return '0;
   endfunction

   assign in_blank  = (in == 4'd0);
   assign nblank_nx = nblank + 7'(in_blank);

`ifdef SD_CHK_TIMEOUT_EN
   // latency has counted TIMEOUT-1 earlier WAIT cycles: this is the last one allowed.
   assign timeout_hit = (latency == 10'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // OR the one-hot masks of the 9 cells of group grp (rows, then columns, then boxes).
   always_comb begin
      int r, c, b;
      r = 0;
      c = 0;
      b = int'(grp) - 18;
      mask = '0;
      for (int k = 0; k < 9; k++) begin
         if (grp < 5'd9) begin
            r = int'(grp);
            c = k;
         end else if (grp < 5'd18) begin
            r = k;
            c = int'(grp) - 9;
         end else begin
            r = (b / 3) * 3 + k / 3;
            c = (b % 3) * 3 + k % 3;
         end
         mask = mask | onehot(grid[7'(r * 9 + c)]);
      end
      grp_ok = (mask == 9'h1FF);
   end

   // Next-state and verdict code; protocol violations end the run immediately.
   always_comb begin
      state_n = state;
      err_n   = err;
      case (state)
         IDLE: if (in_valid) begin
            state_n = LOAD;
            err_n   = 2'd0;
         end
         LOAD: begin
            if (out_valid || !in_valid) begin
               state_n = REPORT;
               err_n   = 2'd2;
            end else if (cnt == 7'd80) begin
               if (nblank_nx != 7'(BLANKS)) begin
                  state_n = REPORT;
                  err_n   = 2'd2;
               end else begin
                  state_n = WAIT;
               end
            end
         end
         WAIT: begin
            if (in_valid) begin
               state_n = REPORT;
               err_n   = 2'd2;
            end else if (out_valid) begin
               state_n = (BLANKS == 1) ? CHECK : COLLECT;
            end else if (timeout_hit) begin
               state_n = REPORT;
               err_n   = 2'd1;
            end
         end
         COLLECT: begin
            if (in_valid || !out_valid) begin
               state_n = REPORT;
               err_n   = 2'd2;
            end else if (dig == BW'(BLANKS - 1)) begin
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (!grp_ok) err_n = 2'd3;
            if (grp == 5'd26) state_n = REPORT;
         end
         REPORT: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Control state, counters and registered outputs (done is high exactly in REPORT).
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         done    <= 1'b0;
         pass    <= 1'b0;
         err     <= 2'd0;
         latency <= '0;
         cnt     <= '0;
         nblank  <= '0;
         dig     <= '0;
         grp     <= '0;
      end else begin
         state <= state_n;
         err   <= err_n;
         done  <= (state_n == REPORT);
         if (state_n == REPORT) pass <= (err_n == 2'd0);
         case (state)
            IDLE: if (in_valid) begin
               pass    <= 1'b0;
               latency <= '0;
               cnt     <= 7'd1;
               nblank  <= 7'(in_blank);
            end
            LOAD: begin
               cnt    <= cnt + 7'd1;
               nblank <= nblank_nx;
            end
            WAIT: begin
               if (latency != 10'h3FF) latency <= latency + 10'd1;
               dig <= BW'(1);
               grp <= '0;
            end
            COLLECT: dig <= dig + BW'(1);
            CHECK:   grp <= grp + 5'd1;
            default: ;
         endcase
      end
   end

   // Grid and blank-index storage; contents are only meaningful after a LOAD.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: if (in_valid) begin
            grid[0] <= in;
            bidx[0] <= 7'd0;
         end
         LOAD: begin
            grid[cnt] <= in;
            if (in_blank && nblank < 7'(BLANKS)) bidx[nblank[BW-1:0]] <= cnt;
         end
         WAIT:    if (out_valid) grid[bidx[0]] <= out;
         COLLECT: if (out_valid) grid[bidx[dig]] <= out;
         default: ;
      endcase
   end

endmodule
